// File: rtl/m21_rr_arbiter_if.sv
// m21_rr_arbiter_if: two requester channels plus the registered output channel of the 2:1 arbiter
interface m21_rr_arbiter_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i0, i1, y;
  logic v0, v1, r0, r1, vy, ry, s0;
  modport master (output i0, v0, i1, v1, ry, input r0, r1, y, vy, s0);
  modport slave (input i0, v0, i1, v1, ry, output r0, r1, y, vy, s0);
endinterface

// File: rtl/m21_rr_arbiter.sv
// m21_rr_arbiter: round-robin 2:1 arbiter feeding a one-word registered output slot
module m21_rr_arbiter #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  m21_rr_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic pri, gnt, load_ok, xfer, s0_q;
  logic [WIDTH-1:0] y_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  // rst_n gates xfer so no ready is raised while reset is held
  always_comb begin
    load_ok = state == EMPTY || bus.ry;
    gnt = bus.v0 && bus.v1 ? pri : bus.v1;
    xfer = rst_n && load_ok && (bus.v0 || bus.v1);
    state_nxt = xfer ? FULL : (bus.ry ? EMPTY : state);
  end
  always_comb begin
    bus.r0 = xfer && !gnt;
    bus.r1 = xfer && gnt;
    bus.vy = state == FULL;
    bus.y = y_q;
    bus.s0 = s0_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y_q <= '0;
      s0_q <= 1'b0;
      pri <= 1'b0;
    end else if (xfer) begin
      y_q <= gnt ? bus.i1 : bus.i0;
      s0_q <= gnt;
      pri <= ~gnt;
    end
endmodule

// File: tb/tb_m21_rr_arbiter.sv
// tb_m21_rr_arbiter: directed and random stimulus with a reference model feeding a scoreboard queue
module tb_m21_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  logic [8:0] q[$];
  logic m_full, m_pri;
  int w0, w1;
  m21_rr_arbiter_if #(.WIDTH(8)) bus ();
  m21_rr_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // reference model and scoreboard, evaluated away from the active edge
  always @(negedge clk) begin
    logic e0, e1, room;
    logic [8:0] w;
    if (!rst_n) begin
      m_full = 1'b0;
      m_pri = 1'b0;
      w0 = 0;
      w1 = 0;
      q.delete();
      chk("rst_r0", bus.r0, 0);
      chk("rst_r1", bus.r1, 0);
      chk("rst_vy", bus.vy, 0);
    end else begin
      chk("mon_vy", bus.vy, m_full);
      room = !m_full || bus.ry;
      e0 = room && bus.v0 && (!bus.v1 || !m_pri);
      e1 = room && bus.v1 && !e0;
      chk("mon_r0", bus.r0, e0);
      chk("mon_r1", bus.r1, e1);
      chk("excl", bus.r0 & bus.r1, 0);
      if (bus.vy && bus.ry) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow actual=%0h required=none", {bus.s0, bus.y});
        end else begin
          w = q.pop_front();
          chk("sb_y", bus.y, w[7:0]);
          chk("sb_s0", bus.s0, w[8]);
        end
      end
      if (e0 || e1) begin
        q.push_back(e1 ? {1'b1, bus.i1} : {1'b0, bus.i0});
        m_pri = e0;
        m_full = 1'b1;
      end else if (bus.ry) m_full = 1'b0;
      w0 = (!bus.v0 || bus.r0) ? 0 : w0 + int'(bus.r1);
      w1 = (!bus.v1 || bus.r1) ? 0 : w1 + int'(bus.r0);
      chk("starve0", w0 > 1, 0);
      chk("starve1", w1 > 1, 0);
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.v0 = 1'b1;
    bus.v1 = 1'b1;
    bus.i0 = 8'h11;
    bus.i1 = 8'h22;
    bus.ry = 1'b1;
    #2;
    chk("rst_hold_r0", bus.r0, 0);
    chk("rst_hold_r1", bus.r1, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_s0", bus.s0, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("first_r0", bus.r0, 1);
    chk("first_r1", bus.r1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_y", bus.y, k[0] ? 8'h22 : 8'h11);
      chk("alt_s0", bus.s0, k[0]);
      chk("alt_vy", bus.vy, 1);
    end
    bus.v0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.i1 = 8'(k);
      #1;
      chk("only1_r0", bus.r0, 0);
      chk("only1_r1", bus.r1, 1);
      step();
      chk("only1_y", bus.y, k);
      chk("only1_s0", bus.s0, 1);
    end
    bus.v0 = 1'b1;
    bus.v1 = 1'b0;
    bus.i0 = 8'hA5;
    step();
    bus.ry = 1'b0;
    bus.v1 = 1'b1;
    bus.i0 = 8'h55;
    bus.i1 = 8'h66;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_r0", bus.r0, 0);
      chk("stall_r1", bus.r1, 0);
      step();
      chk("stall_y", bus.y, 8'hA5);
      chk("stall_s0", bus.s0, 0);
      chk("stall_vy", bus.vy, 1);
    end
    bus.ry = 1'b1;
    #1;
    chk("resume_r1", bus.r1, 1);
    chk("resume_r0", bus.r0, 0);
    step();
    chk("resume_y", bus.y, 8'h66);
    chk("resume_s0", bus.s0, 1);
    bus.v1 = 1'b0;
    bus.i0 = 8'h3C;
    step();
    bus.v0 = 1'b0;
    #1;
    chk("single_vy", bus.vy, 1);
    chk("single_y", bus.y, 8'h3C);
    step();
    chk("idle_vy", bus.vy, 0);
    chk("idle_y", bus.y, 8'h3C);
    chk("idle_s0", bus.s0, 0);
    bus.v0 = 1'b1;
    bus.v1 = 1'b1;
    #1;
    chk("pri1_r1", bus.r1, 1);
    chk("pri1_r0", bus.r0, 0);
    bus.i1 = 8'h7E;
    step();
    chk("pre_rst_y", bus.y, 8'h7E);
    chk("pre_rst_s0", bus.s0, 1);
    bus.ry = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_vy", bus.vy, 0);
    chk("async_y", bus.y, 0);
    chk("async_s0", bus.s0, 0);
    chk("async_r0", bus.r0, 0);
    chk("async_r1", bus.r1, 0);
    step();
    #2 rst_n = 1'b1;
    bus.ry = 1'b1;
    bus.i0 = 8'h81;
    #1;
    chk("post_rst_r0", bus.r0, 1);
    chk("post_rst_r1", bus.r1, 0);
    step();
    chk("post_rst_y", bus.y, 8'h81);
    chk("post_rst_s0", bus.s0, 0);
    for (int k = 0; k < 2000; k++) begin
      bus.v0 = 1'($urandom_range(1));
      bus.v1 = 1'($urandom_range(1));
      bus.ry = 1'($urandom_range(1));
      bus.i0 = 8'($urandom);
      bus.i1 = 8'($urandom);
      step();
    end
    bus.v0 = 1'b0;
    bus.v1 = 1'b0;
    bus.ry = 1'b1;
    step();
    step();
    step();
    chk("drain", q.size(), 0);
    chk("drain_vy", bus.vy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m21_rr_arbiter.md
M21_RR_ARBITER -- requirements
Module: m21_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each input and of the output, legal range 1..32.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 I0  input  WIDTH  data from requester 0.
REQ-005 V0  input  1  requester 0 valid.
REQ-006 R0  output  1  ready to requester 0; a transfer occurs on a cycle with V0 & R0.
REQ-007 I1  input  WIDTH  data from requester 1.
REQ-008 V1  input  1  requester 1 valid.
REQ-009 R1  output  1  ready to requester 1; a transfer occurs on a cycle with V1 & R1.
REQ-010 Y  output  WIDTH  registered output data.
REQ-011 VY  output  1  output valid.
REQ-012 RY  input  1  downstream ready; output handshake completes on a cycle with VY & RY.
REQ-013 S0  output  1  registered select, i.e. the index of the requester whose data is in Y; it drives a 2:1 mux select.

Function
REQ-014 The block SHALL hold one output slot with two states: EMPTY (VY=0) and FULL (VY=1).
REQ-015 LOAD_OK = (state==EMPTY) | RY; this signal is combinational.
REQ-016 Internal priority pointer PRI (1 bit) SHALL name the favoured requester.
REQ-017 Grant: if V0 & V1, grant PRI; if only Vx is high, grant x; if neither is high, there is no grant.
REQ-018 R0 = LOAD_OK & grant==0 & V0; R1 = LOAD_OK & grant==1 & V1; R0 and R1 are combinational and never high together.
REQ-019 On a transfer from x: next edge Y<=Ix, S0<=x, state<=FULL, PRI<=~x.
REQ-020 Latency: accepted data appears on Y with VY=1 exactly one cycle after the transfer edge.
REQ-021 FULL with RY=1 and a new transfer: Y and S0 SHALL be replaced in the same edge and the state stays FULL, giving throughput of one word per cycle.
REQ-022 FULL with RY=1 and no transfer: the state SHALL go to EMPTY, and Y and S0 SHALL hold their last values.
REQ-023 FULL with RY=0: Y, S0, VY and PRI SHALL be held stable; R0=R1=0.
REQ-024 PRI SHALL change only on a transfer; an idle cycle or a stall cycle SHALL leave it unchanged.
REQ-025 With both requesters continuously valid and RY=1, grants SHALL strictly alternate (0,1,0,1,... from reset).
REQ-026 A single continuously valid requester SHALL be granted every cycle; starvation of a waiting requester beyond one transfer is forbidden.
REQ-027 A requester dropping Vx with no transfer is legal; the arbiter SHALL re-evaluate the grant each cycle with no lock.

Reset
REQ-028 When RST_N=0, asynchronously: state=EMPTY, VY=0, Y=0, S0=0, PRI=0.
REQ-029 R0 and R1 SHALL be 0 while RST_N=0, regardless of V0 and V1.
REQ-030 Reset asserted mid-operation SHALL discard the held word; no transfer SHALL be reported on that cycle.
REQ-031 Deassertion is asynchronous to CLK.
REQ-032 The first grant after deassertion follows PRI=0.

Verification
REQ-033 Bench SHALL cover, with WIDTH=8:
- Reset, V0=V1=1, I0=8'h11, I1=8'h22, RY=1 -> Y sequence 11,22,11,22 with S0 sequence 0,1,0,1; VY=1 from the cycle after the first transfer.
- Only V1=1, I1 counting 1..4, RY=1 -> four consecutive transfers; Y=1,2,3,4 on consecutive cycles; S0=1; R0=0 throughout.
- FULL holding 8'hA5 and RY=0 for 5 cycles while V0=V1=1 -> Y=A5 and S0 stable; R0=R1=0; PRI unchanged; after RY=1 the pending grant follows PRI.
- Single transfer I0=8'h3C followed by V0=V1=0 -> VY=1 for one cycle with RY=1; then VY=0, Y holds 3C, PRI=1.
- RST_N pulled low while FULL (Y=8'h7E, S0=1) -> immediately VY=0, Y=0, S0=0, R0=R1=0; after release with V0=V1=1, requester 0 is granted first.
- Random V0/V1/RY over 2000 cycles -> scoreboard shows no lost or duplicated word, R0&R1 never both 1, and no requester waits more than one transfer while continuously valid.
